cdc_stability_monitor: RTL

Parametrised, synthesizable successor to the single-bit glitch monitor. It watches a multi-channel bus synchronous to `clk_i` and flags any channel whose value is not held for at least a programmable number of clock cycles. That is the stability requirement for data crossing into a slower destination domain. It sits on the source side of CDC paths, in both RTL benches and FPGA builds, and reports per-channel pulses, sticky flags, a violation count and the first offending channel.

---
 rtl/cdc_stability_pkg.sv | 19 +
 rtl/cdc_stability_channel.sv | 56 +++++
 rtl/cdc_stability_monitor.sv | 100 ++++++++++
 3 files changed

// File: rtl/cdc_stability_pkg.sv
// Shared types, default widths and helpers for the CDC stability monitor.
package cdc_stability_pkg;

    typedef enum logic [1:0] {
        UNARMED  = 2'd0,
        COUNTING = 2'd1,
        STABLE   = 2'd2
    } stab_state_e;

    localparam int unsigned DEF_CHANNELS = 8;
    localparam int unsigned DEF_CNT_W    = 8;
    localparam int unsigned DEF_VCNT_W   = 16;

    // Increment that sticks at max_val instead of wrapping (widths up to 32 bits).
    function automatic logic [31:0] sat_inc(input logic [31:0] val, input logic [31:0] max_val);
        return (val >= max_val) ? val : val + 32'd1;
    endfunction

endpackage

// File: rtl/cdc_stability_channel.sv
// One monitored channel: arming FSM plus saturating hold counter.
// Optional macro CDC_STABILITY_MON_ASSERT_EN adds a simulation-only
// assertion that reports each violation with its hold length.
module cdc_stability_channel
    import cdc_stability_pkg::*;
#(
    parameter int unsigned CNT_W = DEF_CNT_W
) (
    input  logic             clk_i,
    input  logic             rstn_i,
    input  logic             toggle,
    input  logic             enable,
    input  logic [CNT_W-1:0] min_cycles,
    output logic             viol_c
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    stab_state_e      state;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_inc_c;

    // cnt holds the cycles elapsed since the last edge, so it equals the hold length on the next edge
    assign cnt_inc_c = CNT_W'(sat_inc(32'(cnt), 32'(CNT_MAX)));
    assign viol_c    = enable && toggle && (state == COUNTING) && (cnt < min_cycles);

    // Channel FSM and hold counter
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state <= UNARMED;
            cnt   <= '0;
        end else if (!enable) begin
            state <= UNARMED;
            cnt   <= '0;
        end else if (toggle) begin
            state <= COUNTING;
            cnt   <= CNT_W'(1);
        end else if (state != UNARMED) begin
            cnt <= cnt_inc_c;
            if ((state == COUNTING) && (cnt_inc_c >= min_cycles)) begin
                state <= STABLE;
            end
        end
    end

`ifdef CDC_STABILITY_MON_ASSERT_EN
    // Report each violation with the offending hold length
    always_ff @(posedge clk_i) begin
        if (rstn_i) begin
            assert (!viol_c)
            else $error("%m: hold of %0d cycles below min_cycles %0d", cnt, min_cycles);
        end
    end
`endif

endmodule

// File: rtl/cdc_stability_monitor.sv
// Multi-channel hold-time monitor for source-side CDC data.
// Flags channels whose value changes before min_cycles_i cycles have passed,
// with per-channel pulses, sticky flags, a saturating event count and
// first-offender capture. Optional macro: CDC_STABILITY_MON_ASSERT_EN.
module cdc_stability_monitor
    import cdc_stability_pkg::*;
#(
    parameter  int unsigned CHANNELS = DEF_CHANNELS,
    parameter  int unsigned CNT_W    = DEF_CNT_W,
    parameter  int unsigned VCNT_W   = DEF_VCNT_W,
    localparam int unsigned IDX_W    = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                clk_i,
    input  logic                rstn_i,
    input  logic [CHANNELS-1:0] d_i,
    input  logic [CNT_W-1:0]    min_cycles_i,
    input  logic                enable_i,
    input  logic                clear_i,
    output logic [CHANNELS-1:0] violation_o,
    output logic [CHANNELS-1:0] sticky_o,
    output logic [VCNT_W-1:0]   viol_count_o,
    output logic [IDX_W-1:0]    first_ch_o,
    output logic                first_valid_o
);

    localparam logic [VCNT_W-1:0] VCNT_MAX = '1;

    logic [CHANNELS-1:0] d_q;
    logic [CHANNELS-1:0] toggle_c;
    logic [CHANNELS-1:0] viol_c;
    logic                any_viol_c;
    logic [IDX_W-1:0]    low_idx_c;
    logic [CHANNELS-1:0] sticky_nxt_c;
    logic [VCNT_W-1:0]   count_nxt_c;
    logic [IDX_W-1:0]    first_nxt_c;
    logic                fvalid_nxt_c;

    assign toggle_c   = d_i ^ d_q;
    assign any_viol_c = |viol_c;

    // One FSM per monitored channel
    for (genvar c = 0; c < int'(CHANNELS); c++) begin : g_ch
        cdc_stability_channel #(
            .CNT_W (CNT_W)
        ) u_ch (
            .clk_i      (clk_i),
            .rstn_i     (rstn_i),
            .toggle     (toggle_c[c]),
            .enable     (enable_i),
            .min_cycles (min_cycles_i),
            .viol_c     (viol_c[c])
        );
    end

    // Lowest violating channel index (descending scan leaves the lowest hit)
    always_comb begin
        low_idx_c = '0;
        for (int i = int'(CHANNELS) - 1; i >= 0; i--) begin
            if (viol_c[i]) begin
                low_idx_c = IDX_W'(i);
            end
        end
    end

    // Aggregate next state: clear applies first, this cycle's violations on top
    always_comb begin
        sticky_nxt_c = clear_i ? '0 : sticky_o;
        count_nxt_c  = clear_i ? '0 : viol_count_o;
        first_nxt_c  = clear_i ? '0 : first_ch_o;
        fvalid_nxt_c = clear_i ? 1'b0 : first_valid_o;
        if (any_viol_c) begin
            sticky_nxt_c = sticky_nxt_c | viol_c;
            count_nxt_c  = VCNT_W'(sat_inc(32'(count_nxt_c), 32'(VCNT_MAX)));
            if (!fvalid_nxt_c) begin
                first_nxt_c  = low_idx_c;
                fvalid_nxt_c = 1'b1;
            end
        end
    end

    // Input history and registered reporting outputs
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            d_q           <= '0;
            violation_o   <= '0;
            sticky_o      <= '0;
            viol_count_o  <= '0;
            first_ch_o    <= '0;
            first_valid_o <= 1'b0;
        end else begin
            d_q           <= d_i;
            violation_o   <= viol_c;
            sticky_o      <= sticky_nxt_c;
            viol_count_o  <= count_nxt_c;
            first_ch_o    <= first_nxt_c;
            first_valid_o <= fvalid_nxt_c;
        end
    end

endmodule
